wb_set_assoc_cache: RTL
=======================

WB_SET_ASSOC_CACHE -- requirements
Module: wb_set_assoc_cache

Interface
REQ-001 SHALL have parameter WAY_COUNT, default 2, ways per set (power of 2, >=2).
REQ-002 SHALL have parameter SET_COUNT, default 64, sets (power of 2, >=2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL have ports, one per line:
 clk  in  1  clock;
 reset  in  1  asynchronous, active-high;
 core_req_i  in  1  core request;
 core_addr_i  in  32  byte address;
 core_we_i  in  1  write (1) / read (0);
 core_be_i  in  4  write byte enables;
 core_wdata_i  in  32  write data;
 core_gnt_o  out  1  request accepted;
 core_rvalid_o  out  1  response valid, one cycle;
 core_rdata_o  out  32  read data;
 core_error_o  out  1  error flag, qualified by core_rvalid_o;
 mem_req_o  out  1  memory request;
 mem_addr_o  out  32  word-aligned address;
 mem_we_o  out  1  memory write;
 mem_be_o  out  4  always 4'b1111;
 mem_wdata_o  out  32  memory write data;
 mem_gnt_i  in  1  memory grant;
 mem_rvalid_i  in  1  memory response valid;
 mem_rdata_i  in  32  memory read data;
 mem_error_i  in  1  memory error, qualified by mem_rvalid_i.
REQ-005 SHALL decode addresses as: word = [2 +: log2(LINE_WORDS)], set = next log2(SET_COUNT) bits, tag = remaining upper bits; bits [1:0] ignored.

Function
REQ-006 SHALL be write-back, write-allocate: each line holds valid, dirty, tag and LINE_WORDS data words in internal registers.
REQ-007 SHALL use FSM states IDLE, LOOKUP, EVICT_REQ, EVICT_WAIT, FILL_REQ, FILL_WAIT, UPDATE, RESP.
REQ-008 SHALL assert core_gnt_o combinationally only in IDLE with core_req_i high, capture addr/we/be/wdata that cycle, and go to LOOKUP.
REQ-009 On a LOOKUP hit, SHALL go to UPDATE; a read hit returns the selected word in RESP; a write hit merges only the bytes enabled by core_be_i and sets dirty. Hit latency: core_rvalid_o exactly 3 cycles after the gnt cycle.
REQ-010 On a miss, victim SHALL be the lowest-index invalid way; otherwise the way given by that set's round-robin pointer, which increments modulo WAY_COUNT on every fill into a full set.
REQ-011 If the victim is valid and dirty, SHALL write back all LINE_WORDS words, word 0 first (EVICT_REQ/EVICT_WAIT per word, victim-tag address), then fill; otherwise SHALL fill directly.
REQ-012 Fill SHALL read LINE_WORDS words, word 0 first (FILL_REQ/FILL_WAIT per word); after the last word SHALL set valid=1, dirty=0, tag=request tag, then go to UPDATE to service the request as a hit.
REQ-013 Memory handshake: mem_req_o SHALL hold with stable addr/we/wdata until the cycle mem_gnt_i is high, deassert the next cycle, and wait for mem_rvalid_i; at most one outstanding memory transaction.
REQ-014 mem_error_i with mem_rvalid_i SHALL set a sticky flag for the current request; it SHALL drive core_error_o in RESP. Fill errors SHALL leave the line invalid and write nothing; the read returns 0. A write with an errored fill SHALL be dropped.
REQ-015 core_rvalid_o SHALL be high for exactly one cycle in RESP (also for writes, rdata=0); the next state is IDLE; no new grant is given in RESP.
REQ-016 core_req_i while not in IDLE SHALL be ignored, with core_gnt_o low.

Reset
REQ-017 Reset SHALL clear all valid/dirty bits and round-robin pointers, enter IDLE, and drive every output to 0 except mem_be_o=4'b1111.
REQ-018 Reset mid-transaction SHALL drop mem_req_o immediately; dirty data is discarded; any later mem_rvalid_i is ignored.

Configuration
REQ-019 With macro WB_CACHE_PERF_CNT_EN defined, SHALL add outputs hit_cnt_o and miss_cnt_o (32-bit, reset 0, saturating at 32'hFFFFFFFF), incremented once per LOOKUP hit or miss. Without it, these ports and counters SHALL be absent.

Verification (WAY_COUNT=2, SET_COUNT=4, LINE_WORDS=4; tag=[31:6], set=[5:4])
REQ-020 Cold read 0x100 -> 4 mem reads 0x100..0x10C, then rvalid with mem data of 0x100; repeat read -> hit, rvalid 3 cycles after gnt, no mem traffic.
REQ-021 Write 0x104 data 0xAABBCCDD be=4'b0011 on a cached line holding 0x11223344 -> no mem traffic; read 0x104 returns 0x1122CCDD.
REQ-022 Dirty 0x100, then read 0x200 and 0x300 (same set 0) -> the second miss writes back 0x100..0x10C (mem_we_o=1) before filling 0x300.
REQ-023 mem_gnt_i held low 5 cycles during a fill -> mem_req_o/mem_addr_o stable for all 5 cycles; result correct.
REQ-024 mem_error_i on fill word 2 of read 0x400 -> rvalid with core_error_o=1; next read 0x400 misses again.
REQ-025 Reset asserted in FILL_WAIT -> next cycle mem_req_o=0, state IDLE; read of the previous address misses.

Source files
------------

// File: rtl/wb_set_assoc_cache.sv
// Write-back, write-allocate set-associative cache between a single-issue
// core port and a single-outstanding word memory port. Line state (valid,
// dirty, tag, data words) lives in flops; victims follow lowest-invalid-way
// first, then a per-set round-robin pointer.
// Optional build macro: WB_CACHE_PERF_CNT_EN adds saturating hit/miss
// counter outputs hit_cnt_o / miss_cnt_o.
module wb_set_assoc_cache #(
  parameter int WAY_COUNT  = 2,
  parameter int SET_COUNT  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_error_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_error_i
`ifdef WB_CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int SB = $clog2(SET_COUNT);
  localparam int YB = $clog2(WAY_COUNT);
  localparam int TB = 30 - WB - SB;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOOKUP     = 3'd1;
  localparam logic [2:0] EVICT_REQ  = 3'd2;
  localparam logic [2:0] EVICT_WAIT = 3'd3;
  localparam logic [2:0] FILL_REQ   = 3'd4;
  localparam logic [2:0] FILL_WAIT  = 3'd5;
  localparam logic [2:0] UPDATE     = 3'd6;
  localparam logic [2:0] RESP       = 3'd7;

  logic [2:0]  state;
  // captured request; byte offset bits are not kept
  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [YB-1:0] way_q;
  logic [WB-1:0] cnt_q;
  logic        err_q;
  logic        fill_err_q;
  logic [31:0] rdata_q;

  logic [WAY_COUNT-1:0] valid_q [SET_COUNT];
  logic [WAY_COUNT-1:0] dirty_q [SET_COUNT];
  logic [YB-1:0]        rr_q    [SET_COUNT];
  logic [TB-1:0]        tag_q   [SET_COUNT][WAY_COUNT];
  logic [31:0]          data_q  [SET_COUNT][WAY_COUNT][LINE_WORDS];

  logic [WB-1:0] req_word;
  logic [SB-1:0] req_set;
  logic [TB-1:0] req_tag;
  assign req_word = addr_q[WB-1:0];
  assign req_set  = addr_q[WB +: SB];
  assign req_tag  = addr_q[29 -: TB];

  // Byte offset of the core address is meaningless for a word cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr_i[1:0];

  logic          hit;
  logic [YB-1:0] hit_way;
  logic          inv_found;
  logic [YB-1:0] inv_way;
  logic [YB-1:0] victim;
  logic          victim_dirty;
  logic          last_word;

  // Tag compare across the set, plus lowest-index invalid way search.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (!hit && valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = YB'(w);
      end
      if (!inv_found && !valid_q[req_set][w]) begin
        inv_found = 1'b1;
        inv_way   = YB'(w);
      end
    end
  end

  assign victim       = inv_found ? inv_way : rr_q[req_set];
  assign victim_dirty = valid_q[req_set][victim] && dirty_q[req_set][victim];
  assign last_word    = &cnt_q;

  logic fill_wr;
  logic fill_done;
  logic upd_wr;
  // Only clean fill words land in the array; an errored fill stops writing.
  assign fill_wr   = (state == FILL_WAIT) && mem_rvalid_i && !mem_error_i && !fill_err_q;
  assign fill_done = fill_wr && last_word;
  assign upd_wr    = (state == UPDATE) && we_q;

  // Line data and tag storage; no reset needed since valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_wr) data_q[req_set][way_q][cnt_q] <= mem_rdata_i;
    if (fill_done) tag_q[req_set][way_q] <= req_tag;
    if (upd_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) data_q[req_set][way_q][req_word][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Main controller: request capture, lookup, eviction, fill, update, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      way_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fill_err_q <= 1'b0;
      rdata_q    <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            addr_q     <= core_addr_i[31:2];
            we_q       <= core_we_i;
            be_q       <= core_be_i;
            wdata_q    <= core_wdata_i;
            err_q      <= 1'b0;
            fill_err_q <= 1'b0;
            rdata_q    <= '0;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            way_q <= hit_way;
            state <= UPDATE;
          end else begin
            way_q <= victim;
            cnt_q <= '0;
            // The victim stops being a valid line now; tag/data stay intact
            // for the write-back that may follow.
            valid_q[req_set][victim] <= 1'b0;
            dirty_q[req_set][victim] <= 1'b0;
            if (!inv_found) rr_q[req_set] <= rr_q[req_set] + 1'b1;
            state <= victim_dirty ? EVICT_REQ : FILL_REQ;
          end
        end
        EVICT_REQ: if (mem_gnt_i) state <= EVICT_WAIT;
        EVICT_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_error_i) err_q <= 1'b1;
            cnt_q <= cnt_q + 1'b1;
            state <= last_word ? FILL_REQ : EVICT_REQ;
          end
        end
        FILL_REQ: if (mem_gnt_i) state <= FILL_WAIT;
        FILL_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_error_i) begin
              err_q      <= 1'b1;
              fill_err_q <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
            if (!last_word) begin
              state <= FILL_REQ;
            end else if (fill_err_q || mem_error_i) begin
              // Line stays invalid; reads return 0 and writes are dropped.
              state <= RESP;
            end else begin
              valid_q[req_set][way_q] <= 1'b1;
              dirty_q[req_set][way_q] <= 1'b0;
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (we_q) dirty_q[req_set][way_q] <= 1'b1;
          else rdata_q <= data_q[req_set][way_q][req_word];
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign core_gnt_o    = (state == IDLE) && core_req_i && !reset;
  assign core_rvalid_o = (state == RESP);
  assign core_rdata_o  = (state == RESP) ? rdata_q : '0;
  assign core_error_o  = (state == RESP) && err_q;

  assign mem_req_o   = (state == EVICT_REQ) || (state == FILL_REQ);
  assign mem_we_o    = (state == EVICT_REQ);
  assign mem_be_o    = 4'b1111;
  assign mem_addr_o  = (state == EVICT_REQ) ? {tag_q[req_set][way_q], req_set, cnt_q, 2'b00} :
                       (state == FILL_REQ)  ? {req_tag, req_set, cnt_q, 2'b00} : '0;
  assign mem_wdata_o = (state == EVICT_REQ) ? data_q[req_set][way_q][cnt_q] : '0;

`ifdef WB_CACHE_PERF_CNT_EN
  // Count lookup outcomes, holding at the maximum rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`else
  // Lookup statistics are not tracked in this build.
`endif

endmodule
